// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched word for decode and
// freezes in HALT or FAULT until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 128,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] JumpAddr,
  input  logic [31:0] RegAddr,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] LinkPC,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Fault
);

  localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [31:0] seq_pc;
  logic [31:0] link_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] target;
  logic        target_bad;

  // Branch and jump targets are relative to the instruction being decoded, not the PC.
  always_comb begin
    seq_pc  = pc_q + 32'd4;
    link_pc = instr_pc_q + 32'd4;
    br_pc   = link_pc + {{14{Imm16[15]}}, Imm16, 2'b00};
    jmp_pc  = {link_pc[31:28], JumpAddr, 2'b00};
    unique case (PCSrc)
      2'b00:   target = seq_pc;
      2'b01:   target = br_pc;
      2'b10:   target = jmp_pc;
      2'b11:   target = RegAddr;
      default: target = seq_pc;
    endcase
    target_bad = (target[1:0] != 2'b00) || (target > LastAddr);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      StRun: begin
        if (PCWrite) begin
          if (IDataIn[31:26] == HALT_OPCODE) begin
            instr_d       = IDataIn;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = StHalt;
          end else if (PCSrc != 2'b00) begin
            // Redirect squashes the word at the current PC; no delay slot.
            instr_valid_d = 1'b0;
            if (target_bad) begin
              state_d = StFault;
            end else begin
              pc_d = target;
            end
          end else begin
            instr_d       = IDataIn;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            if (seq_pc > LastAddr) begin
              state_d = StFault;
            end else begin
              pc_d = seq_pc;
            end
          end
        end
      end
      default: instr_valid_d = 1'b0;
    endcase

    halted_d = (state_d == StHalt);
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign IAddr      = pc_q;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign LinkPC     = link_pc;
  assign InstrValid = instr_valid_q;
  assign Halted     = halted_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random stimulus, with a
// reference model feeding an instruction scoreboard and per-cycle state checks.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic [15:0] Imm16;
  logic [25:0] JumpAddr;
  logic [31:0] RegAddr;
  logic [31:0] IDataIn;
  logic [31:0] IAddr;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] LinkPC;
  logic        InstrValid;
  logic        Halted;
  logic        Fault;

  pc_fetch_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .Imm16      (Imm16),
    .JumpAddr   (JumpAddr),
    .RegAddr    (RegAddr),
    .IDataIn    (IDataIn),
    .IAddr      (IAddr),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .LinkPC     (LinkPC),
    .InstrValid (InstrValid),
    .Halted     (Halted),
    .Fault      (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [32];

  always_comb begin
    IDataIn = 32'h0;
    if (IAddr < 32'd128) IDataIn = mem[IAddr[6:2]];
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] link;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state.
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halt, m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd128) return mem[a[6:2]];
    return 32'h0;
  endfunction

  task automatic issue(input logic [31:0] word);
    exp_t e;
    e.instr = word;
    e.ipc   = m_pc;
    e.link  = m_pc + 32'd4;
    exp_q.push_back(e);
    m_instr = word;
    m_ipc   = m_pc;
    m_valid = 1'b1;
  endtask

  task automatic model_step(input logic rst, input logic pcw, input logic [1:0] src,
                            input logic [15:0] imm, input logic [25:0] ja,
                            input logic [31:0] ra);
    logic [31:0] word, nxt, off, t;
    word = mem_word(m_pc);
    nxt  = m_ipc + 32'd4;
    off  = {{16{imm[15]}}, imm} << 2;
    case (src)
      2'd1:    t = nxt + off;
      2'd2:    t = {nxt[31:28], ja, 2'b00};
      2'd3:    t = ra;
      default: t = m_pc + 32'd4;
    endcase
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    end else if (m_halt || m_fault) begin
      m_valid = 1'b0;
    end else if (pcw) begin
      if (word[31:26] == 6'h3F) begin
        issue(word);
        m_halt = 1'b1;
      end else if (src != 2'd0 && (t % 4 != 0 || t > 32'd124)) begin
        m_fault = 1'b1;
        m_valid = 1'b0;
      end else if (src != 2'd0) begin
        m_pc    = t;
        m_valid = 1'b0;
      end else begin
        issue(word);
        if (m_pc + 32'd4 > 32'd124) m_fault = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic pcw, input logic [1:0] src,
                     input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] ra);
    @(negedge CLK);
    Reset = rst; PCWrite = pcw; PCSrc = src; Imm16 = imm; JumpAddr = ja; RegAddr = ra;
    model_step(rst, pcw, src, imm, ja, ra);
    @(posedge CLK);
    #1;
    check("iaddr", IAddr, m_pc);
    check("valid", {31'h0, InstrValid}, {31'h0, m_valid});
    check("halted", {31'h0, Halted}, {31'h0, m_halt});
    check("fault", {31'h0, Fault}, {31'h0, m_fault});
    check("instr", Instr, m_instr);
    check("instr_pc", InstrPC, m_ipc);
  endtask

  task automatic seq_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic stall_n(input int n);
    // Garbage on the redirect inputs must be ignored while stalled.
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd3, 16'hFFFF, 26'h3FF_FFFF, 32'h6);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 2'd0, 16'h0, 26'h0, 32'h0);
  endtask

  // Scoreboard monitor: a new instruction is a valid word whose source address moved.
  logic        mon_prev_valid = 1'b0;
  logic [31:0] mon_prev_ipc   = 32'h0;
  always @(negedge CLK) begin
    if (InstrValid === 1'b1 && (!mon_prev_valid || InstrPC !== mon_prev_ipc)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_instr_pc", InstrPC, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", Instr, e.instr);
        check("sb_instr_pc", InstrPC, e.ipc);
        check("sb_link_pc", LinkPC, e.link);
      end
    end
    mon_prev_valid = (InstrValid === 1'b1);
    mon_prev_ipc   = InstrPC;
  end

  task automatic load_base_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;
  endtask

  initial begin
    logic [31:0] w;
    logic        rst, pcw;
    logic [1:0]  src;
    logic [31:0] ra;
    Reset = 1'b1; PCWrite = 1'b0; PCSrc = 2'd0; Imm16 = 16'h0; JumpAddr = 26'h0; RegAddr = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    load_base_mem();

    // Reset state and sequential fetch.
    do_reset();
    check("reset_iaddr", IAddr, 32'h0);
    check("reset_instr", Instr, 32'h0);
    seq_n(4);
    check("seq_pc16", IAddr, 32'd16);
    check("seq_last_ipc", InstrPC, 32'd12);

    // Stall at PC=8 then release.
    do_reset();
    seq_n(2);
    stall_n(3);
    check("stall_pc", IAddr, 32'd8);
    check("stall_instr", Instr, 32'h2009_0002);
    seq_n(1);
    check("release_instr", Instr, 32'h0109_5020);
    seq_n(1);
    check("pre_branch_ipc", InstrPC, 32'd12);

    // Branch back to 0, then jump to 20, then misaligned JR.
    cyc(1'b0, 1'b1, 2'd1, 16'hFFFC, 26'h0, 32'h0);
    check("branch_pc", IAddr, 32'd0);
    check("branch_bubble", {31'h0, InstrValid}, 32'h0);
    seq_n(1);
    check("branch_word", Instr, 32'h2008_0001);
    cyc(1'b0, 1'b1, 2'd2, 16'h0, 26'd5, 32'h0);
    check("jump_pc", IAddr, 32'd20);
    cyc(1'b0, 1'b1, 2'd3, 16'h0, 26'h0, 32'h6);
    check("jr_fault", {31'h0, Fault}, 32'h1);
    seq_n(3);
    check("fault_pc_hold", IAddr, 32'd20);
    do_reset();
    check("reset_from_fault", {31'h0, Fault}, 32'h0);

    // Halt word at 16.
    mem[4] = 32'hFC00_0000;
    seq_n(5);
    check("halt_word", Instr, 32'hFC00_0000);
    seq_n(3);
    check("halted", {31'h0, Halted}, 32'h1);
    check("halt_pc", IAddr, 32'd16);
    do_reset();
    check("reset_from_halt", {31'h0, Halted}, 32'h0);
    load_base_mem();

    // End of memory: jump to 120 and run off the end.
    cyc(1'b0, 1'b1, 2'd3, 16'h0, 26'h0, 32'd120);
    seq_n(2);
    check("eom_fault", {31'h0, Fault}, 32'h1);
    check("eom_ipc", InstrPC, 32'd124);

    // Reset mid-stall.
    do_reset();
    seq_n(1);
    stall_n(2);
    do_reset();
    check("reset_stall_instr", Instr, 32'h0);

    // Random phase.
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      if ($urandom_range(19) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      mem[i] = w;
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(49) == 0) || ((m_halt || m_fault) && $urandom_range(3) == 0);
      pcw = ($urandom_range(3) != 0);
      src = $urandom_range(1) ? 2'd0 : 2'($urandom_range(3));
      ra  = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(135));
      cyc(rst, pcw, src, 16'(32'($urandom_range(20)) - 32'd10), 26'($urandom_range(35)), ra);
    end

    @(negedge CLK);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
